// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot program loader: FSM encoding, default widths
// and the length-byte decoding rule.
package prog_loader_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W      = 9;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_RUN  = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    // A zero length byte stands for a full 256-byte image.
    function automatic logic [CNT_W-1:0] decode_len(input logic [7:0] b);
        return (b == 8'd0) ? 9'd256 : {1'b0, b};
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Streams a length-prefixed, checksummed program image into RAM while holding
// the CPU, then releases it with a single run pulse on a good checksum.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              cpu_hold,
    output logic              cpu_run,
    output logic              done,
    output logic              err
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic [DATA_W-1:0] wrData_q, wrData_d;
    logic              wren_q, wren_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              xfer;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            addr_q   <= '0;
            wrAddr_q <= '0;
            wrData_q <= '0;
            wren_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            addr_q   <= addr_d;
            wrAddr_q <= wrAddr_d;
            wrData_q <= wrData_d;
            wren_q   <= wren_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign xfer = rx_valid && rx_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        addr_d   = addr_q;
        wrAddr_d = wrAddr_q;
        wrData_d = wrData_q;
        wren_d   = 1'b0;
        done_d   = done_q;
        err_d    = err_q;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LEN;
                    cnt_d   = '0;
                    acc_d   = '0;
                    addr_d  = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ST_LEN: begin
                if (xfer) begin
                    cnt_d   = decode_len(rx_data[7:0]);
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // The write itself is issued from registers one cycle later.
                if (xfer) begin
                    wrAddr_d = addr_q;
                    wrData_d = rx_data;
                    wren_d   = 1'b1;
                    addr_d   = addr_q + ADDR_W'(1);
                    acc_d    = acc_q + rx_data;
                    cnt_d    = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    if (rx_data == acc_q) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rx_ready = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign cpu_hold = rx_ready || (state_q == ST_RUN);
    assign cpu_run  = (state_q == ST_RUN);
    assign done     = done_q;
    assign err      = err_q;

    // The loader owns the RAM port only while the CPU is held.
    assign mem_wren = cpu_hold && wren_q;
    assign mem_addr = cpu_hold ? wrAddr_q : '0;
    assign mem_data = cpu_hold ? wrData_q : '0;

endmodule
